bcd_tx_sequencer: RTL and testbench
===================================

BCD_TX_SEQUENCER -- requirements
Module: bcd_tx_sequencer

Interface
REQ-001 SHALL provide parameter NDIGITS, default 4, meaning number of BCD digits per value (range 1..8).
REQ-002 SHALL provide parameter SEND_CRLF, default 1, meaning 1 appends CR (8'h0D) then LF (8'h0A) after the last digit and 0 sends digits only.
REQ-003 SHALL provide parameter SUPPRESS_LZ, default 0, meaning 1 skips leading zero digits while always sending the least-significant digit.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request to send one value; sampled only in IDLE.
REQ-007 SHALL have port value, input, 4*NDIGITS bits: packed BCD digits, most-significant digit in the top nibble.
REQ-008 SHALL have port tx_data, output, 8 bits: ASCII byte offered to the UART transmitter.
REQ-009 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-010 SHALL have port tx_ready, input, 1 bit: transmitter can accept a byte.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the final byte is accepted.

Function
REQ-013 SHALL map each digit to ASCII as follows: 0..9 becomes 8'h30..8'h39, and any non-BCD nibble (A..F) becomes 8'h23 ('#').
REQ-014 SHALL use FSM states IDLE, SEND, CR, LF, DONE.
REQ-015 IDLE: on start=1, SHALL latch value into an internal shift register, set digit counter to NDIGITS-1, and go to SEND next cycle; value changes after latch SHALL NOT affect output.
REQ-016 A byte SHALL transfer only in a cycle where tx_valid=1 and tx_ready=1.
REQ-017 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-018 SHALL NOT deassert tx_valid before transfer.
REQ-019 SEND: SHALL present the converted top nibble, and on transfer SHALL shift left one nibble and decrement the counter.
REQ-020 SEND: after transferring the last digit (counter=0), SHALL go to CR if SEND_CRLF=1, else DONE.
REQ-021 SUPPRESS_LZ=1: while no nonzero digit has yet been sent and counter>0, a zero top nibble SHALL be skipped in one cycle with tx_valid=0 and no transfer.
REQ-022 SUPPRESS_LZ=1: non-BCD nibbles count as nonzero.
REQ-023 CR SHALL present 8'h0D and go to LF on transfer; LF SHALL present 8'h0A and go to DONE on transfer.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, with tx_valid=0, then return to IDLE.
REQ-025 SHALL ignore start whenever the state is not IDLE; no queuing.
REQ-026 Back-to-back transfers: with tx_ready held high, SHALL transfer one byte per cycle with no gap cycles between bytes.
REQ-027 start asserted in the DONE cycle SHALL be ignored; a new request SHALL be accepted in IDLE no earlier than the cycle after done.
REQ-028 tx_valid SHALL be a registered output; tx_data SHALL depend only on registered state.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, tx_valid=0, tx_data=8'h00, busy=0, done=0, counter=0 and shift register=0, overriding all other inputs.
REQ-030 Reset mid-transfer SHALL abandon the value and send no further bytes; the first post-reset start SHALL send a complete new value.

Verification
REQ-031 Defaults: value=16'h0427, start pulse, tx_ready=1 -> bytes 30,34,32,37,0D,0A on six consecutive cycles, then done pulse, busy low.
REQ-032 Backpressure: value=16'h9105 with tx_ready toggling 1-0-0-1 pattern -> tx_data stable while stalled, sequence 39,31,30,35,0D,0A, no dropped or duplicated bytes.
REQ-033 Invalid digits: value=16'h1A3F -> bytes 31,23,33,23,0D,0A.
REQ-034 SUPPRESS_LZ=1: value=16'h0050 -> 35,30,0D,0A; value=16'h0000 -> 30,0D,0A.
REQ-035 Reset mid-operation: rst in cycle after second byte of 16'h1234 -> tx_valid=0 next cycle, no further bytes; then start with 16'h5678 -> 35,36,37,38,0D,0A.
REQ-036 start pulses while busy and in the DONE cycle -> ignored; exactly one byte sequence per accepted start.

Source files
------------

// File: rtl/bcd_tx_sequencer.sv
// Sends a packed BCD value as ASCII digits, optionally followed by CR/LF,
// over a valid/ready byte interface to a UART transmitter.
module bcd_tx_sequencer #(
    parameter int NDIGITS     = 4,
    parameter int SEND_CRLF   = 1,
    parameter int SUPPRESS_LZ = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   value,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);
    // state | meaning
    // IDLE  | waiting for start
    // SEND  | presenting top nibble of shift register (or skipping a leading zero)
    // CR    | presenting 8'h0D
    // LF    | presenting 8'h0A
    // DONE  | one-cycle done pulse
    localparam int         W        = 4 * NDIGITS;
    localparam logic [2:0] CNT_INIT = 3'(NDIGITS - 1);

    typedef enum logic [2:0] {IDLE, SEND, CR, LF, DONE} state_t;

    state_t         state;
    logic [W-1:0]   shreg;
    logic [2:0]     cnt;
    logic           seen_nz;
    logic [W-1:0]   shifted;
    logic [2:0]     cnt_dec;

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        return (nib <= 4'd9) ? (8'h30 | {4'h0, nib}) : 8'h23;
    endfunction

    function automatic logic is_skip(input logic [W-1:0] sr, input logic [2:0] c,
                                     input logic seen);
        return (SUPPRESS_LZ != 0) && !seen && (c != 3'd0) && (sr[W-1 -: 4] == 4'd0);
    endfunction

    assign shifted = shreg << 4;
    assign cnt_dec = cnt - 3'd1;
    assign busy    = (state != IDLE);

    // Outputs are computed one cycle ahead so tx_valid/tx_data are plain flops.
    // In SEND, tx_valid=0 marks a leading-zero skip cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= 3'd0;
            seen_nz  <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SEND;
                        shreg    <= value;
                        cnt      <= CNT_INIT;
                        seen_nz  <= 1'b0;
                        tx_valid <= !is_skip(value, CNT_INIT, 1'b0);
                        tx_data  <= to_ascii(value[W-1 -: 4]);
                    end
                end
                SEND: begin
                    if (!tx_valid) begin
                        shreg    <= shifted;
                        cnt      <= cnt_dec;
                        tx_valid <= !is_skip(shifted, cnt_dec, seen_nz);
                        tx_data  <= to_ascii(shifted[W-1 -: 4]);
                    end else if (tx_ready) begin
                        // Any digit actually sent ends the leading-zero run.
                        seen_nz <= 1'b1;
                        shreg   <= shifted;
                        if (cnt == 3'd0) begin
                            if (SEND_CRLF != 0) begin
                                state    <= CR;
                                tx_valid <= 1'b1;
                                tx_data  <= 8'h0D;
                            end else begin
                                state    <= DONE;
                                tx_valid <= 1'b0;
                                tx_data  <= 8'h00;
                                done     <= 1'b1;
                            end
                        end else begin
                            cnt      <= cnt_dec;
                            tx_valid <= 1'b1;
                            tx_data  <= to_ascii(shifted[W-1 -: 4]);
                        end
                    end
                end
                CR: begin
                    if (tx_ready) begin
                        state   <= LF;
                        tx_data <= 8'h0A;
                    end
                end
                LF: begin
                    if (tx_ready) begin
                        state    <= DONE;
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_tx_sequencer.sv
// Bench for bcd_tx_sequencer: one default instance and one with leading-zero
// suppression share stimulus; captured bytes are compared to a digit-level model.
module tb_bcd_tx_sequencer;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst, start, tx_ready;
    logic [15:0] value;
    logic [7:0]  d0, d1;
    logic        v0, v1, b0, b1, dn0, dn1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first0, last0;
    int done_cnt0, done_cnt1;
    bq_t q0, q1;
    logic       pv0 = 0, pv1 = 0, pr = 0, prst = 1;
    logic [7:0] pd0 = 0, pd1 = 0;

    always #5 clk = ~clk;

    bcd_tx_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .tx_data(d0), .tx_valid(v0), .tx_ready(tx_ready), .busy(b0), .done(dn0)
    );

    bcd_tx_sequencer #(.NDIGITS(4), .SEND_CRLF(1), .SUPPRESS_LZ(1)) u_lz (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .tx_data(d1), .tx_valid(v1), .tx_ready(tx_ready), .busy(b1), .done(dn1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream from the digit rules: ASCII digits ('#' for A..F),
    // leading zeros dropped when suppressing (last digit always kept), then CR LF.
    function automatic bq_t model(input logic [15:0] v, input bit lz);
        bq_t q;
        int first;
        logic [3:0] nib;
        bit found;
        first = 0;
        if (lz) begin
            first = 3;
            found = 0;
            for (int i = 0; i < 4; i++) begin
                nib = v[15 - 4*i -: 4];
                if (!found && nib != 0) begin
                    first = i;
                    found = 1;
                end
            end
        end
        for (int i = first; i < 4; i++) begin
            nib = v[15 - 4*i -: 4];
            q.push_back(nib <= 9 ? 8'(48 + nib) : 8'h23);
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && !prst) begin
            if (pv0 && !pr) begin
                check("hold_valid0", {31'd0, v0}, 32'd1);
                check("hold_data0", {24'd0, d0}, {24'd0, pd0});
            end
            if (pv1 && !pr) begin
                check("hold_valid1", {31'd0, v1}, 32'd1);
                check("hold_data1", {24'd0, d1}, {24'd0, pd1});
            end
        end
        if (!rst) begin
            if (v0 && tx_ready) begin
                if (q0.size() == 0) first0 = cyc;
                last0 = cyc;
                q0.push_back(d0);
            end
            if (v1 && tx_ready) q1.push_back(d1);
            if (dn0) done_cnt0++;
            if (dn1) done_cnt1++;
        end
        pv0 = v0; pv1 = v1; pd0 = d0; pd1 = d1; pr = tx_ready; prst = rst;
    end

    task automatic compare_q(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_byte%0d", tag, i),
                  {24'd0, (i < got.size()) ? got[i] : 8'hFF}, {24'd0, exp[i]});
    endtask

    // mode 0: ready always high; 1: 1-0-0-1 pattern; 2: random ready
    task automatic run(input logic [15:0] val, input int mode, input bit extra);
        int  k;
        bit  fin;
        q0.delete(); q1.delete();
        done_cnt0 = 0; done_cnt1 = 0;
        value = val; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        value = 16'($urandom);
        fin = 0;
        for (k = 0; k < 200 && !fin; k++) begin
            if (mode == 0)      tx_ready = 1'b1;
            else if (mode == 1) tx_ready = (k % 4 == 0) || (k % 4 == 3);
            else                tx_ready = 1'($urandom_range(0, 1));
            start = extra && (k == 2 || dn0 || dn1);
            @(posedge clk); #1;
            fin = (done_cnt0 > 0) && (done_cnt1 > 0) && !b0 && !b1;
        end
        start = 1'b0; tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("finish_%h", val), {31'd0, fin}, 32'd1);
        compare_q($sformatf("dflt_%h", val), q0, model(val, 0));
        compare_q($sformatf("lz_%h", val), q1, model(val, 1));
        check("done_cnt0", done_cnt0, 32'd1);
        check("done_cnt1", done_cnt1, 32'd1);
        check("busy0_end", {31'd0, b0}, 32'd0);
        check("busy1_end", {31'd0, b1}, 32'd0);
        if (mode == 0) check("no_gap0", last0 - first0, q0.size() - 1);
    endtask

    initial begin
        int k;
        logic [15:0] rv;
        rst = 1'b1; start = 1'b1; tx_ready = 1'b1; value = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, v0}, 32'd0);
        check("rst_data", {24'd0, d0}, 32'd0);
        check("rst_busy", {31'd0, b0}, 32'd0);
        check("rst_done", {31'd0, dn0}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        run(16'h0427, 0, 0);
        run(16'h9105, 1, 0);
        run(16'h1A3F, 0, 0);
        run(16'h0050, 0, 0);
        run(16'h0000, 0, 0);
        run(16'h8421, 0, 1);
        run(16'h7305, 1, 1);

        // reset just after the second byte of 1234
        q0.delete(); q1.delete();
        value = 16'h1234; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 0; k < 20 && q0.size() < 2; k++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_bytes", q0.size(), 32'd2);
        rst = 1'b1; tx_ready = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid0", {31'd0, v0}, 32'd0);
        check("midrst_valid1", {31'd0, v1}, 32'd0);
        check("midrst_busy0", {31'd0, b0}, 32'd0);
        check("midrst_data0", {24'd0, d0}, 32'd0);
        rst = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_bytes0", q0.size(), 32'd2);
        check("post_rst_bytes1", q1.size(), 32'd2);
        run(16'h5678, 0, 0);

        for (int n = 0; n < 8; n++) begin
            for (int j = 0; j < 4; j++)
                rv[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            run(rv, 2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
